move_sched: RTL and testbench

//  Move scheduler between the keyboard decoder and the maze game FSM. Queues direction key

---
 rtl/move_sched.sv | 237 +++++++++++++++++++++++
 tb/tb_move_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sched.sv
// move_sched: queues direction key events, bounds/wall-checks each popped move and issues at most
// one move per drawn frame. Define MOVE_STATS_EN to add saturating acked/blocked move counters.
module move_sched #(
  parameter int DEPTH = 4,
  parameter int MAP_W = 40,
  parameter int MAP_H = 30,
  parameter int AW    = 11
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_fClear,
  input  logic                   i_fEnable,
  input  logic                   i_fKey,
  input  logic [3:0]             i_Dir,
  input  logic [5:0]             i_PosX,
  input  logic [4:0]             i_PosY,
  output logic [AW-1:0]          o_Addr,
  output logic                   o_fRd,
  input  logic                   i_Wall,
  input  logic                   i_fFrameDone,
  output logic                   o_fMove,
  output logic [1:0]             o_Dir,
  input  logic                   i_fMoveAck,
  output logic                   o_fBlocked,
  output logic                   o_fOverflow,
  output logic [$clog2(DEPTH):0] o_Count
`ifdef MOVE_STATS_EN
  ,
  output logic [9:0]             o_MoveCnt,
  output logic [9:0]             o_BlockCnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_U = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  localparam logic signed [6:0] MAP_W_S = 7'(MAP_W);
  localparam logic signed [5:0] MAP_H_S = 6'(MAP_H);
  localparam logic [AW-1:0]     MAP_W_A = AW'(MAP_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK,
    S_WAIT_FRAME,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      mem_q [DEPTH];
  logic [1:0]      mem_d [DEPTH];
  logic [1:0]      dir_q, dir_d;
  logic [5:0]      pos_x_q, pos_x_d;
  logic [4:0]      pos_y_q, pos_y_d;

  logic            push_req;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  logic signed [6:0] tgt_x;
  logic signed [5:0] tgt_y;
  logic              tgt_oob;
  logic [AW-1:0]     tgt_addr;

  function automatic logic [1:0] prio_dir(input logic [3:0] d);
    if (d[3]) return DIR_L;
    if (d[2]) return DIR_U;
    if (d[1]) return DIR_D;
    return DIR_R;
  endfunction

  // Target cell from the position latched at pop; the extra sign bit exposes underflow at edges.
  always_comb begin
    tgt_x = signed'({1'b0, pos_x_q});
    tgt_y = signed'({1'b0, pos_y_q});
    case (dir_q)
      DIR_L:   tgt_x = tgt_x - 7'sd1;
      DIR_R:   tgt_x = tgt_x + 7'sd1;
      DIR_U:   tgt_y = tgt_y - 6'sd1;
      default: tgt_y = tgt_y + 6'sd1;
    endcase
    tgt_oob  = (tgt_x < 7'sd0) || (tgt_x >= MAP_W_S) ||
               (tgt_y < 6'sd0) || (tgt_y >= MAP_H_S);
    tgt_addr = AW'(tgt_y[4:0]) * MAP_W_A + AW'(tgt_x[5:0]);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    dir_d       = dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    pop         = 1'b0;
    push        = 1'b0;
    o_fRd       = 1'b0;
    o_fBlocked  = 1'b0;
    o_fOverflow = 1'b0;
    o_Addr      = '0;
    push_req    = i_fKey && (i_Dir != 4'd0);
    fifo_full   = (count_q == CW'(DEPTH));
    fifo_empty  = (count_q == '0);

    if (i_fClear) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_fEnable && !fifo_empty) begin
            pop     = 1'b1;
            dir_d   = mem_q[rd_ptr_q];
            pos_x_d = i_PosX;
            pos_y_d = i_PosY;
            state_d = S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (tgt_oob) begin
            o_fBlocked = 1'b1;
            state_d    = S_IDLE;
          end else begin
            o_fRd   = 1'b1;
            o_Addr  = tgt_addr;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (i_Wall) begin
            o_fBlocked = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          if (i_fFrameDone) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (i_fMoveAck) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      push        = push_req && (!fifo_full || pop);
      o_fOverflow = push_req && fifo_full && !pop;
      if (push) begin
        mem_d[wr_ptr_q] = prio_dir(i_Dir);
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dir_q    <= DIR_L;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
    end
  end

  // Queue storage carries data only; occupancy and pointers decide what is valid.
  always_ff @(posedge i_Clk) begin
    mem_q <= mem_d;
  end

  assign o_fMove = (state_q == S_HOLD);
  assign o_Dir   = dir_q;
  assign o_Count = count_q;

`ifdef MOVE_STATS_EN
  logic [9:0] move_cnt_q, move_cnt_d;
  logic [9:0] block_cnt_q, block_cnt_d;
  logic       move_acked;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  assign move_acked = (state_q == S_HOLD) && i_fMoveAck && !i_fClear;

  always_comb begin
    move_cnt_d  = move_cnt_q;
    block_cnt_d = block_cnt_q;
    if (i_fClear) begin
      move_cnt_d  = '0;
      block_cnt_d = '0;
    end else begin
      if (move_acked) move_cnt_d  = sat_inc10(move_cnt_q);
      if (o_fBlocked) block_cnt_d = sat_inc10(block_cnt_q);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      move_cnt_q  <= '0;
      block_cnt_q <= '0;
    end else begin
      move_cnt_q  <= move_cnt_d;
      block_cnt_q <= block_cnt_d;
    end
  end

  assign o_MoveCnt  = move_cnt_q;
  assign o_BlockCnt = block_cnt_q;
`endif

endmodule

// File: tb/tb_move_sched.sv
// Bench for move_sched: directed scenarios then randomized key/position/wall traffic checked
// against a queue-based model of the key FIFO and plain target-cell arithmetic.
module tb_move_sched;
  localparam int DEPTH = 4;
  localparam int MAP_W = 40;
  localparam int MAP_H = 30;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          en = 1'b0;
  logic          key = 1'b0;
  logic [3:0]    dir_in = 4'd0;
  logic [5:0]    px = 6'd0;
  logic [4:0]    py = 5'd0;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wall = 1'b0;
  logic          frame = 1'b0;
  logic          mv;
  logic [1:0]    odir;
  logic          ack = 1'b0;
  logic          blk;
  logic          ovf;
  logic [2:0]    cnt;
`ifdef MOVE_STATS_EN
  logic [9:0]    mcnt;
  logic [9:0]    bcnt;
`endif

  int total = 0;
  int bad   = 0;
  int mq[$];

  always #5 clk = ~clk;

  move_sched #(.DEPTH(DEPTH), .MAP_W(MAP_W), .MAP_H(MAP_H), .AW(AW)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .i_fClear     (clr),
    .i_fEnable    (en),
    .i_fKey       (key),
    .i_Dir        (dir_in),
    .i_PosX       (px),
    .i_PosY       (py),
    .o_Addr       (addr),
    .o_fRd        (rd),
    .i_Wall       (wall),
    .i_fFrameDone (frame),
    .o_fMove      (mv),
    .o_Dir        (odir),
    .i_fMoveAck   (ack),
    .o_fBlocked   (blk),
    .o_fOverflow  (ovf),
    .o_Count      (cnt)
`ifdef MOVE_STATS_EN
    ,
    .o_MoveCnt    (mcnt),
    .o_BlockCnt   (bcnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; strobes last exactly one cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
    key   = 1'b0;
    frame = 1'b0;
    ack   = 1'b0;
    clr   = 1'b0;
  endtask

  function automatic int key_code(input logic [3:0] d);
    if (d[3]) return 0;
    if (d[2]) return 1;
    if (d[1]) return 2;
    return 3;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(addr), 0);
    chk({tag, "_rd"},   32'(rd),   0);
    chk({tag, "_move"}, 32'(mv),   0);
    chk({tag, "_dir"},  32'(odir), 0);
    chk({tag, "_blk"},  32'(blk),  0);
    chk({tag, "_ovf"},  32'(ovf),  0);
    chk({tag, "_cnt"},  32'(cnt),  0);
  endtask

  // Key event while no pop can happen in the same cycle.
  task automatic push(input logic [3:0] dv);
    bit exp_ov;
    exp_ov = (dv != 4'd0) && (mq.size() == DEPTH);
    key    = 1'b1;
    dir_in = dv;
    #2;
    chk("overflow_pulse", 32'(ovf), 32'(exp_ov));
    if (dv != 4'd0 && !exp_ov) mq.push_back(key_code(dv));
    nxt();
    chk("count_after_push", 32'(cnt), mq.size());
  endtask

  // Pulse enable for one IDLE cycle so exactly the head entry is popped.
  task automatic start_txn(input int x, input int y);
    px = 6'(x);
    py = 5'(y);
    en = 1'b1;
    #2;
    chk("idle_no_move", 32'(mv), 0);
    nxt();
    en = 1'b0;
    chk("count_after_pop", 32'(cnt), mq.size() - 1);
  endtask

  // Called one cycle after the pop (LOOKUP cycle, time = posedge+1).
  task automatic finish_txn(input int x, input int y, input int d, input bit w,
                            input int gap, input bit do_ack);
    int tx;
    int ty;
    bit oob;
    tx = x;
    ty = y;
    case (d)
      0:       tx = x - 1;
      1:       ty = y - 1;
      2:       ty = y + 1;
      default: tx = x + 1;
    endcase
    oob = (tx < 0) || (tx >= MAP_W) || (ty < 0) || (ty >= MAP_H);
    #2;
    if (oob) begin
      chk("edge_blocked", 32'(blk), 1);
      chk("edge_no_rd",   32'(rd),  0);
      nxt();
      #2;
      chk("edge_blk_one_cycle", 32'(blk), 0);
      chk("edge_no_move",       32'(mv),  0);
      return;
    end
    chk("rd_strobe",     32'(rd),   1);
    chk("rd_addr",       32'(addr), ty * MAP_W + tx);
    chk("lookup_no_blk", 32'(blk),  0);
    nxt();
    wall = w;
    #2;
    chk("rd_one_cycle",  32'(rd),  0);
    chk("wall_blocked",  32'(blk), 32'(w));
    chk("check_no_move", 32'(mv),  0);
    nxt();
    wall = 1'b0;
    #2;
    chk("blk_one_cycle", 32'(blk), 0);
    chk("move_not_yet",  32'(mv),  0);
    if (w) return;
    for (int g = 0; g < gap; g++) begin
      nxt();
      #2;
      chk("move_waits_frame", 32'(mv), 0);
    end
    frame = 1'b1;
    nxt();
    #2;
    chk("move_valid", 32'(mv),   1);
    chk("move_dir",   32'(odir), d);
    for (int h = 0; h < 2; h++) begin
      frame = 1'b1;
      nxt();
      #2;
      chk("move_held",     32'(mv),   1);
      chk("move_dir_held", 32'(odir), d);
    end
    if (!do_ack) return;
    ack = 1'b1;
    #2;
    chk("move_during_ack", 32'(mv), 1);
    nxt();
    #2;
    chk("move_after_ack", 32'(mv), 0);
  endtask

  task automatic do_txn(input int x, input int y, input bit w, input int gap);
    int d;
    d = mq[0];
    start_txn(x, y);
    void'(mq.pop_front());
    finish_txn(x, y, d, w, gap, 1'b1);
  endtask

  initial begin
    int d;
    int n;
    int x;
    int y;
    bit w;
    int gap;

    // Reset state
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    nxt();
    check_all_zero("post_reset");

    // Right move from (1,1) into open cell, acked
    push(4'b0001);
    do_txn(1, 1, 1'b0, 0);
    chk("t1_count_end", 32'(cnt), 0);

    // Up move into a wall
    push(4'b0100);
    do_txn(1, 1, 1'b1, 0);

    // Left move off the left edge: blocked without a map read
    push(4'b1000);
    do_txn(0, 5, 1'b0, 0);

    // Fill while disabled: zero ignored, priority encoding, one overflow
    push(4'b0000);
    push(4'b0110);
    push(4'b0011);
    push(4'b1111);
    push(4'b0001);
    push(4'b0010);
    chk("full_count", 32'(cnt), 4);

    // Push and pop in the same cycle while full
    px     = 6'd10;
    py     = 5'd10;
    en     = 1'b1;
    key    = 1'b1;
    dir_in = 4'b0100;
    #2;
    chk("full_pushpop_no_ovf", 32'(ovf), 0);
    d = mq[0];
    void'(mq.pop_front());
    mq.push_back(1);
    nxt();
    en = 1'b0;
    chk("full_pushpop_count", 32'(cnt), 4);
    finish_txn(10, 10, d, 1'b0, 1, 1'b1);

    // Drain in FIFO order, one move per frame pulse
    while (mq.size() > 0) do_txn(10, 10, 1'b0, 2);
    chk("drain_count", 32'(cnt), 0);

    // Clear during HOLD with two entries still queued
    push(4'b0001);
    push(4'b0001);
    push(4'b0001);
    d = mq[0];
    start_txn(5, 5);
    void'(mq.pop_front());
    finish_txn(5, 5, d, 1'b0, 0, 1'b0);
    chk("hold_count", 32'(cnt), 2);
    clr    = 1'b1;
    key    = 1'b1;
    dir_in = 4'b0001;
    #2;
    chk("clear_no_ovf", 32'(ovf), 0);
    chk("clear_no_blk", 32'(blk), 0);
    nxt();
    mq.delete();
    #2;
    chk("clear_move_drop", 32'(mv),  0);
    chk("clear_count",     32'(cnt), 0);
    push(4'b0010);
    do_txn(5, 5, 1'b0, 0);

    // Clear during CHECK suppresses the wall-blocked pulse
    push(4'b1000);
    start_txn(5, 5);
    void'(mq.pop_front());
    #2;
    chk("clr_chk_rd", 32'(rd), 1);
    nxt();
    wall = 1'b1;
    clr  = 1'b1;
    #2;
    chk("clear_masks_blocked", 32'(blk), 0);
    nxt();
    wall = 1'b0;
    #2;
    chk("clr_chk_move", 32'(mv),  0);
    chk("clr_chk_cnt",  32'(cnt), 0);

    // Asynchronous reset while in CHECK with a wall reported
    push(4'b0001);
    push(4'b0100);
    start_txn(20, 20);
    void'(mq.pop_front());
    #2;
    chk("areset_pre_rd", 32'(rd), 1);
    nxt();
    wall = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    mq.delete();
    wall = 1'b0;
    nxt();
    rst_n = 1'b1;
    nxt();

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) push(4'($urandom_range(0, 15)));
      while (mq.size() > 0) begin
        case ($urandom_range(0, 3))
          0:       x = 0;
          1:       x = MAP_W - 1;
          default: x = $urandom_range(0, 63);
        endcase
        case ($urandom_range(0, 3))
          0:       y = 0;
          1:       y = MAP_H - 1;
          default: y = $urandom_range(0, 31);
        endcase
        w   = 1'($urandom_range(0, 1));
        gap = $urandom_range(0, 3);
        do_txn(x, y, w, gap);
      end
      chk("rand_drained", 32'(cnt), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
